// File: rtl/vec_mem_pkg.sv
// rtl/vec_mem_pkg.sv - shared constants, FSM state type and lane helper for the vector MEM responder
package vec_mem_pkg;

  localparam int LANES  = 6;
  localparam int LANE_W = 8;
  localparam int VEC_W  = LANES * LANE_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DRAIN,
    S_RESP
  } vmem_state_t;

  function automatic logic [LANE_W-1:0] lane_sel(input logic [VEC_W-1:0] word, input logic [2:0] k);
    return word[k*LANE_W +: LANE_W];
  endfunction

endpackage

// File: rtl/vec_mem_responder_if.sv
// rtl/vec_mem_responder_if.sv - request/response and byte-RAM signal bundle for vec_mem_responder
interface vec_mem_responder_if #(
  parameter int ADDR_W = 16
) ();
  import vec_mem_pkg::*;

  logic              req_valid;
  logic              req_write;
  logic              req_bcast;
  logic [ADDR_W-1:0] req_addr;
  logic [VEC_W-1:0]  req_wdata;
  logic              req_ready;
  logic              stall;
  logic              rsp_valid;
  logic [VEC_W-1:0]  rsp_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_re;
  logic [LANE_W-1:0] ram_wdata;
  logic [LANE_W-1:0] ram_rdata;

  modport master (
    output req_valid, req_write, req_bcast, req_addr, req_wdata, ram_rdata,
    input  req_ready, stall, rsp_valid, rsp_rdata, ram_addr, ram_we, ram_re, ram_wdata
  );

  modport slave (
    input  req_valid, req_write, req_bcast, req_addr, req_wdata, ram_rdata,
    output req_ready, stall, rsp_valid, rsp_rdata, ram_addr, ram_we, ram_re, ram_wdata
  );

endinterface

// File: rtl/vec_lane_reg.sv
// rtl/vec_lane_reg.sv - 48-bit gather register with per-lane byte enables, broadcast write and sync clear
module vec_lane_reg
  import vec_mem_pkg::*;
(
  input  logic              clk,
  input  logic              i_clr_n,
  input  logic [LANES-1:0]  i_lane_we,
  input  logic              i_bcast_we,
  input  logic [LANE_W-1:0] i_byte,
  output logic [VEC_W-1:0]  o_word
);

  logic [VEC_W-1:0] r_word;

  // Broadcast takes priority so a scalar operand fills every lane in one write.
  always_ff @(posedge clk) begin
    if (!i_clr_n) begin
      r_word <= '0;
    end else if (i_bcast_we) begin
      r_word <= {LANES{i_byte}};
    end else begin
      for (int i = 0; i < LANES; i++) begin
        if (i_lane_we[i]) r_word[i*LANE_W +: LANE_W] <= i_byte;
      end
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/vec_mem_responder.sv
// rtl/vec_mem_responder.sv - serialises 48-bit vector loads/stores into byte RAM accesses (option: VEC_MEM_BCAST_EN)
module vec_mem_responder
  import vec_mem_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int LANES  = 6,
  parameter int LANE_W = 8
) (
  input logic                clk,
  input logic                rst,
  vec_mem_responder_if.slave bus
);

  localparam int LAST_K = LANES - 1;

  vmem_state_t       r_state;
  vmem_state_t       w_next;
  logic [ADDR_W-1:0] r_base;
  logic              r_write;
  logic              r_bcast;
  logic [VEC_W-1:0]  r_wdata;
  logic [2:0]        r_k;
  logic              r_pend;
  logic [2:0]        r_pend_lane;

  logic              w_accept;
  logic              w_bcast_in;
  logic              w_last_k;
  logic [ADDR_W-1:0] w_addr;
  logic [LANE_W-1:0] w_lane;
  logic [LANES-1:0]  w_lane_we;
  logic              w_gather_clr_n;
  logic [VEC_W-1:0]  w_gather;

`ifdef VEC_MEM_BCAST_EN
  assign w_bcast_in = bus.req_bcast && !bus.req_write;
`else
  logic w_unused_bcast;
  assign w_unused_bcast = bus.req_bcast;
  assign w_bcast_in     = 1'b0;
`endif

  assign w_accept = (r_state == S_IDLE) && bus.req_valid;
  assign w_last_k = (r_k == 3'(LAST_K));
  assign w_addr   = r_base + ADDR_W'(r_k);
  assign w_lane   = lane_sel(r_wdata, r_k);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_base      <= '0;
      r_write     <= 1'b0;
      r_bcast     <= 1'b0;
      r_wdata     <= '0;
      r_k         <= '0;
      r_pend      <= 1'b0;
      r_pend_lane <= '0;
    end else begin
      r_state     <= w_next;
      r_pend      <= (r_state == S_READ);
      r_pend_lane <= r_k;
      if (w_accept) begin
        r_base  <= bus.req_addr;
        r_write <= bus.req_write;
        r_bcast <= w_bcast_in;
        r_wdata <= bus.req_wdata;
        r_k     <= '0;
      end else if (r_state == S_WRITE || r_state == S_READ) begin
        r_k <= r_k + 3'd1;
      end
    end
  end

  // Read data arrives one cycle after its strobe, so capture is steered by the lane issued last cycle.
  always_comb begin
    w_lane_we = '0;
    for (int i = 0; i < LANES; i++) begin
      if (r_pend && !r_bcast && (r_pend_lane == 3'(i))) w_lane_we[i] = 1'b1;
    end
  end

  assign w_gather_clr_n = rst && !w_accept;

  vec_lane_reg u_gather (
    .clk        (clk),
    .i_clr_n    (w_gather_clr_n),
    .i_lane_we  (w_lane_we),
    .i_bcast_we (r_pend && r_bcast),
    .i_byte     (bus.ram_rdata),
    .o_word     (w_gather)
  );

  // Strobes are masked while reset is low so an aborted store writes nothing further.
  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.stall     = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.ram_addr  = '0;
    bus.ram_we    = 1'b0;
    bus.ram_re    = 1'b0;
    bus.ram_wdata = '0;
    case (r_state)
      S_IDLE: begin
        bus.req_ready = 1'b1;
        bus.stall     = bus.req_valid;
        if (bus.req_valid) w_next = bus.req_write ? S_WRITE : S_READ;
      end
      S_WRITE: begin
        bus.stall     = 1'b1;
        bus.ram_we    = rst;
        bus.ram_addr  = w_addr;
        bus.ram_wdata = w_lane;
        if (w_last_k) w_next = S_RESP;
      end
      S_READ: begin
        bus.stall    = 1'b1;
        bus.ram_re   = rst;
        bus.ram_addr = w_addr;
        if (w_last_k || r_bcast) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        bus.stall = 1'b1;
        w_next    = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = rst;
        bus.rsp_rdata = r_write ? '0 : w_gather;
        w_next        = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_vec_mem_responder.sv
// tb/tb_vec_mem_responder.sv - directed self-checking bench for vec_mem_responder
module tb_vec_mem_responder;
  import vec_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   re_cnt = 0;
  int   rsp_cnt = 0;
  logic [7:0] mem [0:65535];

  vec_mem_responder_if #(.ADDR_W(16)) bus ();

  vec_mem_responder #(.ADDR_W(16), .LANES(6), .LANE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    if (bus.ram_re) begin
      bus.ram_rdata <= mem[bus.ram_addr];
      re_cnt <= re_cnt + 1;
    end
    if (bus.rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  function automatic logic [47:0] mem_word(input logic [15:0] a);
    logic [47:0] w;
    for (int k = 0; k < 6; k++) w[8*k +: 8] = mem[a + 16'(k)];
    return w;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if ({bus.req_ready, bus.stall, bus.rsp_valid, bus.rsp_rdata, bus.ram_addr, bus.ram_we, bus.ram_re, bus.ram_wdata}
        !== {1'b1, 1'b0, 1'b0, 48'h0, 16'h0, 1'b0, 1'b0, 8'h0}) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%b stall=%b rsp=%b rdata=%h addr=%h we=%b re=%b wdata=%h",
               bus.req_ready, bus.stall, bus.rsp_valid, bus.rsp_rdata, bus.ram_addr, bus.ram_we, bus.ram_re, bus.ram_wdata);
    end
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 16'h0500; bus.req_wdata = 48'h1;
    @(negedge clk);
    n_chk++;
    if ({bus.req_ready, bus.ram_we} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_drops_req: ready=%b we=%b want ready=1 we=0", bus.req_ready, bus.ram_we);
    end
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({bus.req_ready, bus.stall, bus.ram_we} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_release_idle: ready=%b stall=%b we=%b", bus.req_ready, bus.stall, bus.ram_we);
    end
  endtask

  task automatic test_store(input logic [15:0] a, input logic [47:0] d, input logic b);
    logic [15:0] ea;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_bcast = b; bus.req_addr = a; bus.req_wdata = d;
    #1;
    n_chk++;
    if ({bus.stall, bus.req_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL store_c0_stall: stall=%b ready=%b want 1 1", bus.stall, bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_addr = 16'h0; bus.req_wdata = 48'h0; bus.req_bcast = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ea = a + 16'(k);
      n_chk++;
      if ({bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata, bus.stall, bus.rsp_valid}
          !== {1'b1, 1'b0, ea, d[8*k +: 8], 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL store_c%0d: we=%b re=%b addr=%h wdata=%h stall=%b rsp=%b want we=1 re=0 addr=%h wdata=%h stall=1 rsp=0",
                 k + 1, bus.ram_we, bus.ram_re, bus.ram_addr, bus.ram_wdata, bus.stall, bus.rsp_valid, ea, d[8*k +: 8]);
      end
      @(negedge clk);
    end
    n_chk++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.stall, bus.ram_we} !== {1'b1, 48'h0, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL store_c7_rsp: rsp=%b rdata=%h stall=%b we=%b want 1 0 0 0", bus.rsp_valid, bus.rsp_rdata, bus.stall, bus.ram_we);
    end
    @(negedge clk);
    n_chk++;
    if ({bus.req_ready, bus.rsp_valid} !== 2'b10) begin
      n_err++;
      $display("FAIL store_c8_idle: ready=%b rsp=%b want 1 0", bus.req_ready, bus.rsp_valid);
    end
    n_chk++;
    if (mem_word(a) !== d) begin
      n_err++;
      $display("FAIL store_mem: got %h want %h at %h", mem_word(a), d, a);
    end
  endtask

  task automatic test_load(input logic [15:0] a, input logic [47:0] exp);
    logic [15:0] ea;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_bcast = 1'b0; bus.req_addr = a;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_addr = 16'h0;
    for (int k = 0; k < 6; k++) begin
      ea = a + 16'(k);
      n_chk++;
      if ({bus.ram_re, bus.ram_we, bus.ram_addr, bus.rsp_valid} !== {1'b1, 1'b0, ea, 1'b0}) begin
        n_err++;
        $display("FAIL load_c%0d: re=%b we=%b addr=%h rsp=%b want re=1 we=0 addr=%h rsp=0",
                 k + 1, bus.ram_re, bus.ram_we, bus.ram_addr, bus.rsp_valid, ea);
      end
      @(negedge clk);
    end
    n_chk++;
    if ({bus.ram_re, bus.rsp_valid, bus.stall} !== 3'b001) begin
      n_err++;
      $display("FAIL load_c7_drain: re=%b rsp=%b stall=%b want 0 0 1", bus.ram_re, bus.rsp_valid, bus.stall);
    end
    @(negedge clk);
    n_chk++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.stall} !== {1'b1, exp, 1'b0}) begin
      n_err++;
      $display("FAIL load_c8_rsp: rsp=%b rdata=%h stall=%b want rsp=1 rdata=%h stall=0", bus.rsp_valid, bus.rsp_rdata, bus.stall, exp);
    end
    @(negedge clk);
  endtask

  task automatic test_bcast();
    int re0;
    int exp_re;
    logic [47:0] exp;
    test_store(16'h0020, 48'h05040302017A, 1'b0);
    re0 = re_cnt;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_bcast = 1'b1; bus.req_addr = 16'h0020;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_bcast = 1'b0; bus.req_addr = 16'h0;
`ifdef VEC_MEM_BCAST_EN
    exp_re = 1;
    exp = 48'h7A7A7A7A7A7A;
    n_chk++;
    if ({bus.ram_re, bus.ram_addr} !== {1'b1, 16'h0020}) begin
      n_err++;
      $display("FAIL bcast_c1: re=%b addr=%h want 1 0020", bus.ram_re, bus.ram_addr);
    end
    @(negedge clk);
    n_chk++;
    if ({bus.ram_re, bus.rsp_valid, bus.stall} !== 3'b001) begin
      n_err++;
      $display("FAIL bcast_c2_drain: re=%b rsp=%b stall=%b want 0 0 1", bus.ram_re, bus.rsp_valid, bus.stall);
    end
    @(negedge clk);
`else
    exp_re = 6;
    exp = 48'h05040302017A;
    repeat (7) @(negedge clk);
`endif
    n_chk++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, exp}) begin
      n_err++;
      $display("FAIL bcast_rsp: rsp=%b rdata=%h want rsp=1 rdata=%h", bus.rsp_valid, bus.rsp_rdata, exp);
    end
    @(negedge clk);
    n_chk++;
    if (re_cnt - re0 !== exp_re) begin
      n_err++;
      $display("FAIL bcast_read_count: got %0d want %0d", re_cnt - re0, exp_re);
    end
  endtask

  task automatic test_reset_mid();
    int r0;
    test_store(16'h0300, 48'h0, 1'b0);
    r0 = rsp_cnt;
    bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_addr = 16'h0300; bus.req_wdata = 48'hAABBCCDDEEFF;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_chk++;
    if ({bus.ram_we, bus.rsp_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL rstmid_c3_strobe: we=%b rsp=%b want 0 0", bus.ram_we, bus.rsp_valid);
    end
    @(negedge clk);
    n_chk++;
    if ({bus.req_ready, bus.stall, bus.rsp_valid, bus.rsp_rdata, bus.ram_addr, bus.ram_we, bus.ram_re, bus.ram_wdata}
        !== {1'b1, 1'b0, 1'b0, 48'h0, 16'h0, 1'b0, 1'b0, 8'h0}) begin
      n_err++;
      $display("FAIL rstmid_outputs: ready=%b stall=%b rsp=%b addr=%h we=%b re=%b wdata=%h",
               bus.req_ready, bus.stall, bus.rsp_valid, bus.ram_addr, bus.ram_we, bus.ram_re, bus.ram_wdata);
    end
    rst = 1'b1;
    repeat (10) @(negedge clk);
    n_chk++;
    if (rsp_cnt !== r0) begin
      n_err++;
      $display("FAIL rstmid_no_rsp: got %0d responses want 0", rsp_cnt - r0);
    end
    n_chk++;
    if (mem_word(16'h0300) !== 48'h00000000EEFF) begin
      n_err++;
      $display("FAIL rstmid_mem: got %h want 00000000eeff", mem_word(16'h0300));
    end
  endtask

  task automatic test_ignore_busy();
    int t;
    bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_bcast = 1'b0; bus.req_addr = 16'h0100;
    @(negedge clk);
    bus.req_addr = 16'h0300; bus.req_write = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_chk++;
      if ({bus.ram_re, bus.ram_we, bus.ram_addr} !== {1'b1, 1'b0, 16'h0100 + 16'(k)}) begin
        n_err++;
        $display("FAIL busy_c%0d: re=%b we=%b addr=%h want re=1 we=0 addr=%h",
                 k + 1, bus.ram_re, bus.ram_we, bus.ram_addr, 16'h0100 + 16'(k));
      end
      @(negedge clk);
    end
    n_chk++;
    if (bus.req_ready !== 1'b0) begin
      n_err++;
      $display("FAIL busy_c7_ready: got %b want 0", bus.req_ready);
    end
    @(negedge clk);
    n_chk++;
    if ({bus.rsp_valid, bus.rsp_rdata, bus.req_ready} !== {1'b1, 48'h665544332211, 1'b0}) begin
      n_err++;
      $display("FAIL busy_c8_rsp: rsp=%b rdata=%h ready=%b want 1 665544332211 0", bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
    end
    bus.req_write = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.req_ready, bus.stall} !== 2'b11) begin
      n_err++;
      $display("FAIL busy_c9_accept: ready=%b stall=%b want 1 1", bus.req_ready, bus.stall);
    end
    @(negedge clk);
    bus.req_valid = 1'b0;
    n_chk++;
    if ({bus.ram_re, bus.ram_addr} !== {1'b1, 16'h0300}) begin
      n_err++;
      $display("FAIL busy_second_addr: re=%b addr=%h want 1 0300", bus.ram_re, bus.ram_addr);
    end
    t = 0;
    while (bus.rsp_valid !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_chk++;
    if ({bus.rsp_valid, bus.rsp_rdata} !== {1'b1, 48'h00000000EEFF}) begin
      n_err++;
      $display("FAIL busy_second_rsp: rsp=%b rdata=%h want 1 00000000eeff", bus.rsp_valid, bus.rsp_rdata);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_bcast = 1'b0;
    bus.req_addr  = 16'h0;
    bus.req_wdata = 48'h0;
    @(negedge clk);
    test_reset();
    test_store(16'h0100, 48'h665544332211, 1'b0);
    test_load(16'h0100, 48'h665544332211);
    test_store(16'hFFFD, 48'h0A0B0C0D0E0F, 1'b1);
    test_bcast();
    test_reset_mid();
    test_ignore_busy();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/vec_mem_responder.md
# vec_mem_responder

Memory-side responder for the vector pipeline's MEM stage. Accepts one 48-bit vector load or store request per transaction and serialises it into six byte-wide accesses on an 8-bit data RAM. Loads are gathered back into a 48-bit word for writeback. The block holds the pipeline stalled while a transaction is in flight.

## Interface
Parameters:
- `ADDR_W`, 16: byte address width.
- `LANES`, 6: vector lanes per word.
- `LANE_W`, 8: bits per lane. The vector width is `LANES*LANE_W` (48).

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `req_valid`, in, 1: request from the MEM stage.
- `req_write`, in, 1: 1 = store, 0 = load.
- `req_bcast`, in, 1: broadcast load; see Configuration.
- `req_addr`, in, ADDR_W: base byte address (ALU result bits 15:0).
- `req_wdata`, in, 48: store data. Lane k is bits 8k+7:8k.
- `req_ready`, out, 1: block can accept a request.
- `stall`, out, 1: holds the fetch and upstream pipeline registers.
- `rsp_valid`, out, 1: one-cycle completion pulse.
- `rsp_rdata`, out, 48: load result, valid while `rsp_valid` is high.
- `ram_addr`, out, ADDR_W: RAM byte address.
- `ram_we`, out, 1: RAM write strobe.
- `ram_re`, out, 1: RAM read strobe.
- `ram_wdata`, out, 8: RAM write byte.
- `ram_rdata`, in, 8: RAM read byte. It is valid in the cycle after the matching `ram_re` cycle.

## Operation
- FSM states: IDLE, WRITE, READ, DRAIN, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, the block latches `req_write`, `req_bcast`, `req_addr` and `req_wdata`, and clears the lane counter k.
  - It then goes to WRITE if `req_write`=1, otherwise to READ.
- WRITE:
  - Each cycle drives `ram_we`=1, `ram_addr`=base+k and `ram_wdata`=lane k, then increments k.
  - After k=5 goes to RESP.
- READ:
  - Each cycle drives `ram_re`=1 and `ram_addr`=base+k, then increments k.
  - After the last issue goes to DRAIN.
- Capture: every cycle, the byte returned for the address issued in the previous cycle is written into its lane of the result register.
- DRAIN: captures the final byte, then goes to RESP.
- RESP:
  - `rsp_valid`=1.
  - `rsp_rdata` is the gathered word for a load and 0 for a store.
  - Goes to IDLE.
- Address arithmetic: base+k is computed modulo 2^ADDR_W, so 0xFFFE+3 = 0x0001.
- Inputs are sampled only at acceptance. Changes on `req_*` while busy are ignored.
- `req_valid` outside IDLE is ignored. It is not queued.
- `stall` = (state != IDLE && state != RESP) || (state==IDLE && `req_valid`).
- `ram_we` and `ram_re` are never high in the same cycle. Both are 0 in IDLE, DRAIN and RESP.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `stall`=0 (given `req_valid`=0), `rsp_valid`=0, `rsp_rdata`=0, `ram_addr`=0, `ram_we`=0, `ram_re`=0, `ram_wdata`=0.
- Acceptance edge is cycle 0.
- Store: `ram_we` is high in cycles 1–6 and `rsp_valid` is high in cycle 7. Next acceptance is possible in cycle 8.
- Load: `ram_re` is high in cycles 1–6, data returns in cycles 2–7, and `rsp_valid` is high in cycle 8.
- Broadcast load: `ram_re` is high in cycle 1 only, data returns in cycle 2, and `rsp_valid` is high in cycle 3.
- Reset low mid-transaction:
  - Next state is IDLE.
  - No further RAM strobes.
  - No `rsp_valid`.
  - RAM bytes already written stay written.
- Reset low in the same cycle as `req_valid`: reset wins and the request is dropped.

## Configuration
- `VEC_MEM_BCAST_EN` defined:
  - A load with `req_bcast`=1 issues a single read at base.
  - The returned byte is replicated into all six lanes, matching the datapath's scalar-broadcast operand path.
  - `req_bcast` on a store is ignored.
- Undefined: the `req_bcast` port still exists but is ignored. Every load performs six reads.

## Structure
- Package `vec_mem_pkg` holds:
  - constants `LANES`, `LANE_W` and `VEC_W`;
  - the FSM state enum `vmem_state_t`;
  - the lane-select helper function (lane k slice of a 48-bit word).
- One sub-module, `vec_lane_reg`: a 48-bit register with a per-lane byte write enable, a broadcast-write input and a synchronous active-low clear. It is used for the load gather register.
- Counter, FSM and address adder are inline in the top module.

## Test plan
- Store 0x665544332211 to 0x0100 → `ram_we` cycles 1–6 write 0x11..0x66 to 0x0100..0x0105. `rsp_valid` in cycle 7, `stall` high in cycles 0–6.
- Load from 0x0100 with the RAM preloaded as above → `rsp_rdata`=0x665544332211 with `rsp_valid` in cycle 8.
- Store at 0xFFFD → writes go to 0xFFFD, 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0002.
- With `VEC_MEM_BCAST_EN`, broadcast load from 0x0020 holding 0x7A → one `ram_re`, `rsp_rdata`=0x7A7A7A7A7A7A in cycle 3. Without the macro, the same stimulus gives six reads.
- Reset asserted in cycle 3 of a store → only bytes 0–1 written, no `rsp_valid`, all outputs at reset values next cycle.
- `req_valid` held high during a load with `req_addr` changing → only the originally latched address is used. The second request is accepted only after returning to IDLE.
